// File: rtl/inference_monitor_pkg.sv
// +--------------------------------------------------------------------+
// | inference_monitor_pkg : shared types for the inference monitor     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package inference_monitor_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 64;

   typedef enum logic [1:0] {
      MON_IDLE = 2'd0,
      MON_RUN  = 2'd1,
      MON_DONE = 2'd2
   } mon_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] img_idx;
      logic [DATA_W-1:0] corr_cnt;
      logic [CNT_W-1:0]  latency;
   } log_t;

   localparam int unsigned LOG_W = $bits(log_t);

endpackage

`default_nettype wire

// File: rtl/inference_monitor_log_fifo.sv
// +--------------------------------------------------------------------+
// | monitor_log_fifo : synchronous FIFO holding per-image log entries  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module monitor_log_fifo
   import inference_monitor_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = LOG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/inference_monitor.sv
// +--------------------------------------------------------------------+
// | inference_monitor : snoops GPR writes, tracks per-image latency    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module inference_monitor
   import inference_monitor_pkg::*;
#(
   parameter int unsigned D_WIDTH     = DATA_W,
   parameter int unsigned CNT_WIDTH   = CNT_W,
   parameter int unsigned NUM_OF_TEST = 100,
   parameter int unsigned IMG_REG     = 26,
   parameter int unsigned CORR_REG    = 27,
   parameter int unsigned EXIT_REG    = 25,
   parameter int unsigned EXIT_MAGIC  = 99999,
   parameter int unsigned LOG_DEPTH   = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 clear_i,
   input  logic                 rf_we_i,
   input  logic [4:0]           rf_waddr_i,
   input  logic [D_WIDTH-1:0]   rf_wdata_i,
   input  logic                 retire_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [D_WIDTH-1:0]   img_idx_o,
   output logic [D_WIDTH-1:0]   corr_cnt_o,
   output logic [CNT_WIDTH-1:0] cycle_o,
   output logic [CNT_WIDTH-1:0] instret_o,
   output logic [CNT_WIDTH-1:0] lat_min_o,
   output logic [CNT_WIDTH-1:0] lat_max_o,
   output logic                 log_valid_o,
   input  logic                 log_ready_i,
   output log_t                 log_data_o,
   output logic                 overflow_o,
   output logic                 range_err_o
);

   mon_state_e           state;
   mon_state_e           state_nxt;
   logic                 run;
   logic [D_WIDTH-1:0]   img_idx;
   logic [D_WIDTH-1:0]   corr_cnt;
   logic [CNT_WIDTH-1:0] cycle_cnt;
   logic [CNT_WIDTH-1:0] instret_cnt;
   logic [CNT_WIDTH-1:0] lat_cnt;
   logic [CNT_WIDTH-1:0] lat_inc;
   logic [CNT_WIDTH-1:0] lat_min;
   logic [CNT_WIDTH-1:0] lat_max;
   logic                 overflow;
   logic                 range_err;
   logic                 snoop;
   logic                 img_wr;
   logic                 corr_wr;
   logic                 exit_hit;
   logic                 boundary;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [LOG_W-1:0]     fifo_rdata;
   log_t                 entry;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= MON_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run       = 1'b0;
      done_o    = 1'b0;
      case (state)
         MON_IDLE: if (start_i) state_nxt = MON_RUN;
         MON_RUN: begin
            run = 1'b1;
            if (exit_hit) state_nxt = MON_DONE;
         end
         MON_DONE: done_o = 1'b1;
         default:  state_nxt = MON_IDLE;
      endcase
      if (clear_i) state_nxt = MON_IDLE;
   end

   assign snoop    = run & rf_we_i & (rf_waddr_i != 5'd0);
   assign img_wr   = snoop & (rf_waddr_i == 5'(IMG_REG));
   assign corr_wr  = snoop & (rf_waddr_i == 5'(CORR_REG));
   assign exit_hit = snoop & (rf_waddr_i == 5'(EXIT_REG)) & (rf_wdata_i == D_WIDTH'(EXIT_MAGIC));
   assign boundary = img_wr & (rf_wdata_i != img_idx);
   assign push     = boundary | exit_hit;
   assign lat_inc  = lat_cnt + CNT_WIDTH'(1);
   assign pop      = log_ready_i & ~fifo_empty;
   assign entry    = '{img_idx: img_idx, corr_cnt: corr_cnt, latency: lat_inc};

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         img_idx     <= '0;
         corr_cnt    <= '0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
         lat_cnt     <= '0;
         lat_min     <= '1;
         lat_max     <= '0;
         overflow    <= 1'b0;
         range_err   <= 1'b0;
      end else if (run) begin
         cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
         if (retire_i) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
         lat_cnt <= boundary ? '0 : lat_inc;
         if (img_wr)  img_idx  <= rf_wdata_i;
         if (corr_wr) corr_cnt <= rf_wdata_i;
         // Min/max track every completed image even when its log entry is dropped.
         if (push) begin
            if (lat_inc < lat_min) lat_min <= lat_inc;
            if (lat_inc > lat_max) lat_max <= lat_inc;
         end
         if (push && fifo_full && !log_ready_i) overflow <= 1'b1;
         if (img_wr && (rf_wdata_i >= D_WIDTH'(NUM_OF_TEST))) range_err <= 1'b1;
      end
   end

   monitor_log_fifo #(
      .DEPTH (LOG_DEPTH),
      .WIDTH (LOG_W)
   ) u_log_fifo (
      .clk   (clk_i),
      .rst   (rst_i | clear_i),
      .push  (push),
      .wdata (entry),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign busy_o      = run;
   assign img_idx_o   = img_idx;
   assign corr_cnt_o  = corr_cnt;
   assign cycle_o     = cycle_cnt;
   assign instret_o   = instret_cnt;
   assign lat_min_o   = lat_min;
   assign lat_max_o   = lat_max;
   assign log_valid_o = ~fifo_empty;
   assign log_data_o  = log_t'(fifo_rdata);
   assign overflow_o  = overflow;
   assign range_err_o = range_err;

endmodule

`default_nettype wire

// File: tb/tb_inference_monitor.sv
// +--------------------------------------------------------------------+
// | tb_inference_monitor : scoreboard bench for inference_monitor      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_inference_monitor;
   import inference_monitor_pkg::*;

   localparam logic [4:0] IMG  = 5'd26;
   localparam logic [4:0] CORR = 5'd27;
   localparam logic [4:0] EXIT = 5'd25;
   localparam logic [63:0] ONES = {64{1'b1}};

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        clear_i = 1'b0;
   logic        rf_we_i = 1'b0;
   logic [4:0]  rf_waddr_i = '0;
   logic [31:0] rf_wdata_i = '0;
   logic        retire_i = 1'b0;
   logic        log_ready_i = 1'b0;
   logic        busy_o, done_o, log_valid_o, overflow_o, range_err_o;
   logic [31:0] img_idx_o, corr_cnt_o;
   logic [63:0] cycle_o, instret_o, lat_min_o, lat_max_o;
   log_t        log_data_o;

   int   vectors = 0;
   int   miscompares = 0;
   log_t sb[$];

   always #5 clk = ~clk;

   inference_monitor dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
      .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
      .retire_i(retire_i), .busy_o(busy_o), .done_o(done_o),
      .img_idx_o(img_idx_o), .corr_cnt_o(corr_cnt_o), .cycle_o(cycle_o),
      .instret_o(instret_o), .lat_min_o(lat_min_o), .lat_max_o(lat_max_o),
      .log_valid_o(log_valid_o), .log_ready_i(log_ready_i), .log_data_o(log_data_o),
      .overflow_o(overflow_o), .range_err_o(range_err_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic start();
      start_i = 1'b1; tick(); start_i = 1'b0;
   endtask

   task automatic clear();
      clear_i = 1'b1; tick(); clear_i = 1'b0;
   endtask

   // Optional pop checks the current head against the scoreboard before the edge.
   task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit do_pop);
      log_t exp;
      rf_we_i = 1'b1; rf_waddr_i = a; rf_wdata_i = d;
      if (do_pop) begin
         exp = (sb.size() > 0) ? sb.pop_front() : log_t'('0);
         vectors++;
         if (log_valid_o !== 1'b1 || log_data_o !== exp) begin
            miscompares++;
            $display("FAIL pop_head: valid=%0b data=%h want valid=1 data=%h", log_valid_o, log_data_o, exp);
         end
         log_ready_i = 1'b1;
      end
      tick();
      rf_we_i = 1'b0; log_ready_i = 1'b0;
   endtask

   task automatic drain(input string tag);
      int   n;
      log_t exp;
      n = sb.size();
      for (int k = 0; k < n; k++) begin
         exp = sb.pop_front();
         vectors++;
         if (log_valid_o !== 1'b1 || log_data_o !== exp) begin
            miscompares++;
            $display("FAIL %s_entry%0d: valid=%0b data=%h want valid=1 data=%h", tag, k, log_valid_o, log_data_o, exp);
         end
         log_ready_i = 1'b1; tick(); log_ready_i = 1'b0;
      end
      vectors++;
      if (log_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_empty: log_valid=%0b want 0", tag, log_valid_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; run(3); rst_i = 1'b0;
      vectors++;
      if ({busy_o, done_o, log_valid_o, overflow_o, range_err_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 00000", {busy_o, done_o, log_valid_o, overflow_o, range_err_o});
      end
      vectors++;
      if (cycle_o !== 64'd0 || instret_o !== 64'd0 || lat_max_o !== 64'd0 || img_idx_o !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_counters: cycle=%0d instret=%0d lat_max=%0d img=%0d want all 0", cycle_o, instret_o, lat_max_o, img_idx_o);
      end
      vectors++;
      if (lat_min_o !== ONES) begin
         miscompares++;
         $display("FAIL reset_lat_min: got %h want %h", lat_min_o, ONES);
      end
   endtask

   task automatic test_counters();
      int n_ret = 0;
      start();
      for (int k = 0; k < 10; k++) begin
         retire_i = k[0];
         if (k[0]) n_ret++;
         tick();
      end
      retire_i = 1'b0;
      vectors++;
      if (cycle_o !== 64'd10 || instret_o !== 64'(n_ret)) begin
         miscompares++;
         $display("FAIL counters: cycle=%0d instret=%0d want cycle=10 instret=%0d", cycle_o, instret_o, n_ret);
      end
      vectors++;
      if (busy_o !== 1'b1 || log_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL counters_state: busy=%0b log_valid=%0b want busy=1 log_valid=0", busy_o, log_valid_o);
      end
   endtask

   task automatic test_latency();
      clear(); start();
      run(10); wr(CORR, 32'd5, 1'b0);
      run(9);  sb.push_back(log_t'{32'd0, 32'd5, 64'd21}); wr(IMG, 32'd1, 1'b0);
      run(9);  wr(CORR, 32'd7, 1'b0);
      wr(5'd0, 32'd77, 1'b0);
      run(18); sb.push_back(log_t'{32'd1, 32'd7, 64'd30}); wr(IMG, 32'd2, 1'b0);
      wr(IMG, 32'd2, 1'b0);
      vectors++;
      if (lat_min_o !== 64'd21 || lat_max_o !== 64'd30) begin
         miscompares++;
         $display("FAIL lat_minmax: min=%0d max=%0d want min=21 max=30", lat_min_o, lat_max_o);
      end
      vectors++;
      if (img_idx_o !== 32'd2 || corr_cnt_o !== 32'd7) begin
         miscompares++;
         $display("FAIL shadows: img=%0d corr=%0d want img=2 corr=7", img_idx_o, corr_cnt_o);
      end
      drain("latency");
   endtask

   task automatic test_overflow();
      clear(); start();
      for (int i = 1; i <= 8; i++) begin
         sb.push_back(log_t'{32'(i - 1), 32'd0, 64'd1});
         wr(IMG, 32'(i), 1'b0);
      end
      run(5);
      wr(IMG, 32'd9, 1'b0);
      vectors++;
      if (overflow_o !== 1'b1 || lat_max_o !== 64'd6 || lat_min_o !== 64'd1) begin
         miscompares++;
         $display("FAIL overflow_drop: ovf=%0b max=%0d min=%0d want ovf=1 max=6 min=1", overflow_o, lat_max_o, lat_min_o);
      end
      drain("overflow");
      clear(); start();
      for (int i = 1; i <= 8; i++) begin
         sb.push_back(log_t'{32'(i - 1), 32'd0, 64'd1});
         wr(IMG, 32'(i), 1'b0);
      end
      sb.push_back(log_t'{32'd8, 32'd0, 64'd1});
      wr(IMG, 32'd9, 1'b1);
      vectors++;
      if (overflow_o !== 1'b0) begin
         miscompares++;
         $display("FAIL full_push_pop: ovf=%0b want 0", overflow_o);
      end
      drain("pushpop");
   endtask

   task automatic test_exit();
      clear(); start();
      run(5); wr(CORR, 32'd3, 1'b0);
      run(4); wr(EXIT, 32'd99998, 1'b0);
      vectors++;
      if (busy_o !== 1'b1 || done_o !== 1'b0 || log_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL exit_wrong_magic: busy=%0b done=%0b valid=%0b want 1 0 0", busy_o, done_o, log_valid_o);
      end
      sb.push_back(log_t'{32'd0, 32'd3, 64'd12});
      wr(EXIT, 32'd99999, 1'b0);
      vectors++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || cycle_o !== 64'd12) begin
         miscompares++;
         $display("FAIL exit_done: done=%0b busy=%0b cycle=%0d want 1 0 12", done_o, busy_o, cycle_o);
      end
      retire_i = 1'b1; start_i = 1'b1; tick(); start_i = 1'b0;
      wr(IMG, 32'd4, 1'b0);
      run(18);
      retire_i = 1'b0;
      vectors++;
      if (cycle_o !== 64'd12 || instret_o !== 64'd0 || done_o !== 1'b1 || img_idx_o !== 32'd0) begin
         miscompares++;
         $display("FAIL exit_frozen: cycle=%0d instret=%0d done=%0b img=%0d want 12 0 1 0", cycle_o, instret_o, done_o, img_idx_o);
      end
      drain("exit");
   endtask

   task automatic test_range();
      clear(); start();
      sb.push_back(log_t'{32'd0, 32'd0, 64'd1});
      wr(IMG, 32'd99, 1'b0);
      vectors++;
      if (range_err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL range_99: range_err=%0b want 0", range_err_o);
      end
      wr(IMG, 32'd100, 1'b0);
      wr(IMG, 32'd5, 1'b0);
      vectors++;
      if (range_err_o !== 1'b1 || img_idx_o !== 32'd5) begin
         miscompares++;
         $display("FAIL range_sticky: range_err=%0b img=%0d want 1 5", range_err_o, img_idx_o);
      end
      clear_i = 1'b1; start_i = 1'b1; tick(); clear_i = 1'b0; start_i = 1'b0;
      sb.delete();
      vectors++;
      if ({busy_o, range_err_o, log_valid_o, overflow_o} !== 4'b0 || cycle_o !== 64'd0 ||
          img_idx_o !== 32'd0 || corr_cnt_o !== 32'd0 || lat_max_o !== 64'd0 || lat_min_o !== ONES) begin
         miscompares++;
         $display("FAIL clear_state: busy=%0b rerr=%0b valid=%0b cycle=%0d img=%0d min=%h want all cleared",
                  busy_o, range_err_o, log_valid_o, cycle_o, img_idx_o, lat_min_o);
      end
   endtask

   task automatic test_reset_midrun();
      start();
      wr(IMG, 32'd1, 1'b0); wr(IMG, 32'd2, 1'b0); wr(IMG, 32'd3, 1'b0);
      run(2);
      vectors++;
      if (log_valid_o !== 1'b1 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrun_pre: valid=%0b busy=%0b want 1 1", log_valid_o, busy_o);
      end
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b0 || log_valid_o !== 1'b0 || lat_min_o !== ONES || cycle_o !== 64'd0) begin
         miscompares++;
         $display("FAIL midrun_reset: busy=%0b valid=%0b min=%h cycle=%0d want 0 0 all-ones 0",
                  busy_o, log_valid_o, lat_min_o, cycle_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_counters();
      test_latency();
      test_overflow();
      test_exit();
      test_range();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
